// File: rtl/tpu_pkg.sv
// Shared TPU definitions: array geometry defaults,
// index width derivation and the C-tile drain FSM states.
package tpu_pkg;

    localparam int M_DEF      = 8;
    localparam int N_DEF      = 8;
    localparam int DATA_W_DEF = 32;

    // Index width for a dimension of n entries, never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_REQ  = 2'd1,
        DR_WAIT = 2'd2,
        DR_FIN  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/c_tile_drain_if.sv
// C-tile drain bus: C-SRAM read port plus the element output stream.
// master = drain engine, slave = SRAM/consumer side.
interface c_tile_drain_if
    import tpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ROW_W  = idx_w(M_DEF),
    parameter int COL_W  = idx_w(N_DEF)
);
    logic              c_rd_en;
    logic              c_rd_re;
    logic [ROW_W-1:0]  c_rd_row;
    logic [COL_W-1:0]  c_rd_col;
    logic [DATA_W-1:0] c_rd_rdata;
    logic              c_rd_rvalid;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic              out_last;

    modport master (
        output c_rd_en, c_rd_re, c_rd_row, c_rd_col,
        input  c_rd_rdata, c_rd_rvalid,
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  c_rd_en, c_rd_re, c_rd_row, c_rd_col,
        output c_rd_rdata, c_rd_rvalid,
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/c_drain_fifo.sv
// Two-entry output FIFO for drained C elements.
// Push and pop in the same cycle both take effect, even when full.
module c_drain_fifo #(
    parameter int W = 39
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         empty_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] dout_o
);
    logic [W-1:0] mem_q [2];
    logic         wp_q;
    logic         rp_q;
    logic [1:0]   cnt_q;
    logic         pop;
    logic         wr;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign valid_o = !empty_o;
    assign dout_o  = mem_q[rp_q];
    assign pop     = valid_o && ready_i;
    assign wr      = push_i && (!full_o || pop);

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (wr) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_q + 2'(wr) - 2'(pop);
        end
    end
endmodule

// File: rtl/c_tile_drain.sv
// Drains an MxN C tile from C-SRAM in row-major order into a
// two-deep element stream, one read outstanding, with read timeout.
module c_tile_drain
    import tpu_pkg::*;
#(
    parameter int M       = M_DEF,
    parameter int N       = N_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROW_W   = idx_w(M),
    parameter int COL_W   = idx_w(N),
    parameter int TMO_CYC = 2000
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           drain_done,
    output logic           err_tmo,
    c_tile_drain_if.master bus
);
    localparam int PW = DATA_W + ROW_W + COL_W + 1;
    localparam int TW = $clog2(TMO_CYC + 1);

    drain_state_e     state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             err_q, err_d;

    logic             is_last;
    logic             rd_req;
    logic             push;
    logic             done;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PW-1:0]    fifo_din;
    logic [PW-1:0]    fifo_dout;

    assign is_last = (row_q == ROW_W'(M - 1)) && (col_q == COL_W'(N - 1));
    assign fifo_din = {bus.c_rd_rdata, row_q, col_q, is_last};

    // Drain sequencing: request, wait for data or timeout, finish.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        rd_req  = 1'b0;
        push    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            DR_IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    err_d   = 1'b0;
                    state_d = DR_REQ;
                end
            end
            DR_REQ: begin
                if (!fifo_full) begin
                    rd_req  = 1'b1;
                    tmo_d   = '0;
                    state_d = DR_WAIT;
                end
            end
            DR_WAIT: begin
                if (bus.c_rd_rvalid) begin
                    push = 1'b1;
                    if (is_last) begin
                        state_d = DR_FIN;
                    end else begin
                        if (col_q == COL_W'(N - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        state_d = DR_REQ;
                    end
                end else if (tmo_q == TW'(TMO_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = DR_FIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DR_FIN: begin
                if (fifo_empty) begin
                    done    = 1'b1;
                    state_d = DR_IDLE;
                end
            end
            default: state_d = DR_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DR_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    c_drain_fifo #(
        .W(PW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (fifo_din),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .valid_o (bus.out_valid),
        .ready_i (bus.out_ready),
        .dout_o  (fifo_dout)
    );

    assign {bus.out_data, bus.out_row, bus.out_col, bus.out_last} = fifo_dout;

    assign bus.c_rd_en  = rd_req;
    assign bus.c_rd_re  = rd_req;
    assign bus.c_rd_row = row_q;
    assign bus.c_rd_col = col_q;

    assign busy       = (state_q != DR_IDLE);
    assign drain_done = done;
    assign err_tmo    = err_q;
endmodule

// File: tb/tb_c_tile_drain.sv
// Bench for c_tile_drain: SRAM model with programmable latency,
// consumer with several ready patterns, row-major reference stream.
module tb_c_tile_drain;
    localparam int M   = 8;
    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int RW  = 3;
    localparam int CW  = 3;
    localparam int TMO = 2000;
    localparam int NB  = M * N;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic drain_done;
    logic err_tmo;

    c_tile_drain_if #(.DATA_W(DW), .ROW_W(RW), .COL_W(CW)) bus ();

    c_tile_drain #(
        .M(M), .N(N), .DATA_W(DW), .ROW_W(RW), .COL_W(CW), .TMO_CYC(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .drain_done (drain_done),
        .err_tmo    (err_tmo),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // SRAM contents as a function of address
    function automatic logic [DW-1:0] mem_word(input int r, input int c);
        return {8'(r), 8'(c), 16'hA5A5};
    endfunction

    // k-th element of the row-major drain stream
    function automatic logic [63:0] exp_beat(input int k);
        int r;
        int c;
        r = k / N;
        c = k % N;
        return 64'({mem_word(r, c), RW'(r), CW'(c), (k == NB - 1)});
    endfunction

    function automatic logic [63:0] outs();
        return 64'({busy, drain_done, err_tmo, bus.c_rd_en, bus.c_rd_re,
                    bus.c_rd_row, bus.c_rd_col, bus.out_valid,
                    bus.out_data, bus.out_row, bus.out_col, bus.out_last});
    endfunction

    int cyc = 0;
    int lat = 1;
    int rmode = 0;
    bit no_resp = 1'b0;
    bit stray = 1'b0;
    bit orphan = 1'b0;
    bit pend = 1'b0;
    int pcnt = 0;
    logic [RW-1:0] prow;
    logic [CW-1:0] pcol;
    int beats, reads, dones, first_v, last_cyc, done_cyc;
    bit pstall = 1'b0;
    logic [63:0] ppay;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SRAM model, consumer and stream monitor
    initial begin
        logic [63:0] pay;
        bus.c_rd_rvalid = 1'b0;
        bus.c_rd_rdata  = '0;
        bus.out_ready   = 1'b0;
        forever begin
            @(negedge clk);
            bus.c_rd_rvalid = 1'b0;
            if (stray) begin
                bus.c_rd_rvalid = 1'b1;
                bus.c_rd_rdata  = 32'hDEAD_BEEF;
                stray = 1'b0;
            end else if (pend) begin
                if (pcnt <= 1) begin
                    pend = 1'b0;
                    if (!no_resp) begin
                        bus.c_rd_rvalid = 1'b1;
                        bus.c_rd_rdata  = mem_word(int'(prow), int'(pcol));
                    end
                end else begin
                    pcnt--;
                end
            end
            case (rmode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ~bus.out_ready;
                2: bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
            #1;
            pay = 64'({bus.out_data, bus.out_row, bus.out_col, bus.out_last});
            if (pstall) begin
                chk("stall_valid", 64'(bus.out_valid), 1);
                chk("stall_payload", pay, ppay);
            end
            pstall = bus.out_valid && !bus.out_ready;
            ppay   = pay;
            if (bus.out_valid && bus.out_ready) begin
                if (beats == 0) first_v = cyc;
                chk("beat", pay, exp_beat(beats));
                beats++;
                last_cyc = cyc;
            end
            if (bus.c_rd_en || bus.c_rd_re) begin
                chk("rd_re_eq_en", 64'(bus.c_rd_re), 64'(bus.c_rd_en));
                chk("one_outstanding", 64'(pend), 0);
                pend   = 1'b1;
                orphan = 1'b0;
                pcnt   = lat;
                prow   = bus.c_rd_row;
                pcol   = bus.c_rd_col;
                reads++;
            end else if (pend && !orphan) begin
                chk("addr_stable", 64'({bus.c_rd_row, bus.c_rd_col}),
                    64'({prow, pcol}));
            end
            if (drain_done) begin
                dones++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clr_stats();
        beats    = 0;
        reads    = 0;
        dones    = 0;
        first_v  = -1;
        last_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic pulse_start(output int sc);
        @(negedge clk);
        start = 1'b1;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (dones == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(dones != 0), 1);
    endtask

    task automatic run_full(input string tag, input int l, input int rm,
                            input int es, output int sc);
        lat   = l;
        rmode = rm;
        clr_stats();
        pulse_start(sc);
        chk({tag, "_err_cleared"}, 64'(err_tmo), 0);
        chk({tag, "_busy"}, 64'(busy), 1);
        if (es > 0) begin
            repeat (es) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(tag, 5000);
        repeat (4) @(negedge clk);
        chk({tag, "_beats"}, 64'(beats), NB);
        chk({tag, "_reads"}, 64'(reads), NB);
        chk({tag, "_dones"}, 64'(dones), 1);
        chk({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_cyc + 1));
        chk({tag, "_busy_low"}, 64'(busy), 0);
        chk({tag, "_err"}, 64'(err_tmo), 0);
    endtask

    initial begin
        int sc;
        int n;
        rst   = 1'b1;
        start = 1'b0;
        clr_stats();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", outs(), 0);
        @(negedge clk);
        rst = 1'b0;

        run_full("lat1", 1, 0, 0, sc);
        chk("first_latency", 64'(first_v - sc), 3);

        run_full("lat3_toggle", 3, 1, 0, sc);

        lat   = 1;
        rmode = 3;
        clr_stats();
        pulse_start(sc);
        repeat (50) @(negedge clk);
        chk("hold_reads", 64'(reads), 2);
        chk("hold_beats", 64'(beats), 0);
        chk("hold_busy", 64'(busy), 1);
        rmode = 0;
        wait_done("hold", 5000);
        repeat (4) @(negedge clk);
        chk("hold_total_reads", 64'(reads), NB);
        chk("hold_total_beats", 64'(beats), NB);
        chk("hold_dones", 64'(dones), 1);

        no_resp = 1'b1;
        lat     = 1;
        rmode   = 0;
        clr_stats();
        pulse_start(sc);
        wait_done("tmo", TMO + 100);
        repeat (2) @(negedge clk);
        chk("tmo_err", 64'(err_tmo), 1);
        chk("tmo_done_cyc", 64'(done_cyc - sc), TMO + 2);
        chk("tmo_busy", 64'(busy), 0);
        chk("tmo_beats", 64'(beats), 0);
        chk("tmo_reads", 64'(reads), 1);
        chk("tmo_dones", 64'(dones), 1);
        no_resp = 1'b0;

        run_full("restart_ignored", 2, 2, 20, sc);

        lat   = 3;
        rmode = 0;
        clr_stats();
        pulse_start(sc);
        n = 0;
        while (beats < 20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_beat20", 64'(beats >= 20), 1);
        rst    = 1'b1;
        orphan = 1'b1;
        @(negedge clk);
        #1;
        chk("midrun_rst_outs", outs(), 0);
        rst = 1'b0;
        clr_stats();
        repeat (6) @(negedge clk);
        #2;
        stray = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("post_rst_beats", 64'(beats), 0);
        chk("post_rst_reads", 64'(reads), 0);
        chk("post_rst_busy", 64'(busy), 0);
        chk("post_rst_valid", 64'(bus.out_valid), 0);

        run_full("after_rst", 2, 0, 0, sc);

        for (int i = 0; i < 3; i++) begin
            run_full("random", int'($urandom_range(1, 4)), 2, 0, sc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/c_tile_drain.md
C_TILE_DRAIN -- requirements
Module: c_tile_drain

Interface
REQ-001 Parameters SHALL be: M, default 8, array rows; N, default 8, array columns; DATA_W, default 32, element width; ROW_W, default clog2(M) (min 1), row index width; COL_W, default clog2(N) (min 1), column index width; TMO_CYC, default 2000, read timeout in cycles.
REQ-002 Ports SHALL be (name  direction  width  meaning):
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse, drive from upstream systolic wrapper done; begins drain of the C tile.
REQ-006 busy  out  1  high from accepted start until drain_done.
REQ-007 drain_done  out  1  one-cycle pulse after the last element leaves the output port.
REQ-008 err_tmo  out  1  sticky; set on read timeout, cleared only by rst or accepted start.
REQ-009 c_rd_en, c_rd_re  out  1 each  C-SRAM read request, driven identically.
REQ-010 c_rd_row, c_rd_col  out  ROW_W, COL_W  C-SRAM read address.
REQ-011 c_rd_rdata  in  DATA_W  C-SRAM read data; c_rd_rvalid  in  1  read data valid.
REQ-012 out_valid  out  1; out_ready  in  1; out_data  out  DATA_W; out_row  out  ROW_W; out_col  out  COL_W; out_last  out  1: element stream.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, FIN.
REQ-014 IDLE: start=1 -> clear row/col counters to 0, clear err_tmo, go REQ; start outside IDLE SHALL be ignored.
REQ-015 REQ: if output FIFO has a free slot, assert c_rd_en=c_rd_re=1 for exactly one cycle with current row/col, go WAIT; else hold in REQ with c_rd_en=0.
REQ-016 c_rd_row/c_rd_col SHALL hold stable from request cycle until rvalid or timeout.
REQ-017 WAIT: c_rd_rvalid=1 -> push {c_rd_rdata,row,col,last} into FIFO, last=1 iff row=M-1 and col=N-1; then if last go FIN, else advance index and go REQ.
REQ-018 Index order row-major: col increments first; col=N-1 wraps to 0 with row+1.
REQ-019 c_rd_rvalid outside WAIT SHALL be ignored; at most one read outstanding.
REQ-020 WAIT timeout counter resets on entry; reaching TMO_CYC cycles without rvalid -> set err_tmo, push nothing, go FIN.
REQ-021 FIN: when FIFO empty and no beat presenting, pulse drain_done one cycle, go IDLE.
REQ-022 Output FIFO depth 2; out_valid = FIFO non-empty; beat transfers when out_valid & out_ready.
REQ-023 While out_valid=1 and out_ready=0, out_data/out_row/out_col/out_last SHALL stay stable.
REQ-024 Simultaneous push and pop on a full or non-empty FIFO SHALL both occur; count unchanged.
REQ-025 Minimum latency start -> first out_valid: 1 (REQ) + SRAM latency + 1 cycle.
REQ-026 busy=1 in REQ, WAIT, FIN; 0 in IDLE.

Reset
REQ-027 rst SHALL force IDLE, counters 0, FIFO empty, and all outputs 0 (busy, drain_done, err_tmo, c_rd_*, out_*), including mid-drain.
REQ-028 rvalid arriving after rst from a pre-reset request SHALL be ignored.

Structure
REQ-029 Shared package tpu_pkg SHALL hold default M, N, DATA_W, the ROW_W/COL_W derivation, and the drain FSM state enum.
REQ-030 FIFO SHALL be sub-module c_drain_fifo (depth 2, payload DATA_W+ROW_W+COL_W+1).

Verification
REQ-031 M=N=8; SRAM model latency 1, rdata={row,col,16'hA5A5} style pattern; out_ready=1 -> 64 beats in row-major order, out_last only on beat 64 (7,7), drain_done one cycle after it.
REQ-032 Same with SRAM latency 3 and out_ready toggling 1/0 every cycle -> identical 64-beat sequence, no payload change while stalled, never >1 read outstanding.
REQ-033 out_ready=0 for 50 cycles after start -> exactly 2 reads issued, then c_rd_en stays 0; release -> remaining 62 reads complete.
REQ-034 SRAM model never returns rvalid -> err_tmo=1 after 2000 WAIT cycles, drain_done pulses, busy falls.
REQ-035 Second start pulse during drain -> ignored, still exactly 64 beats; rst at beat 20 -> all outputs 0 next cycle, late rvalid ignored, fresh start yields full 64 beats.
